// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Definitions shared by the LED pulse stretcher.
//   led_state_t        : per-channel FSM state (IDLE, ON, GAP), 2-bit encoded
//   DEFAULT_ON_LIMIT   : 50 ms LED on-time at a 12 MHz clock
//   DEFAULT_GAP_LIMIT  : 25 ms forced off-time at a 12 MHz clock
//   DEFAULT_COUNT_SIZE : counter width large enough for both defaults
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  localparam int unsigned DEFAULT_ON_LIMIT   = 600000;
  localparam int unsigned DEFAULT_GAP_LIMIT  = 300000;
  localparam int unsigned DEFAULT_COUNT_SIZE = 20;

endpackage

// File: rtl/led_stretch_chan.sv
// ---------------------------------------------------------------------------
// led_stretch_chan
// One LED channel: stretches single-cycle event strobes into a pulse of
// ON_LIMIT cycles followed by a forced off-gap of GAP_LIMIT cycles. Events
// arriving while the channel is busy collapse into one queued pulse.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   event_in : event strobe, every high cycle counts as one event
//   led      : registered LED drive, active-high
//   busy     : registered, high whenever the channel is not idle
// ---------------------------------------------------------------------------
module led_stretch_chan
  import led_pkg::*;
#(
  parameter int unsigned ON_LIMIT   = DEFAULT_ON_LIMIT,
  parameter int unsigned GAP_LIMIT  = DEFAULT_GAP_LIMIT,
  parameter int unsigned COUNT_SIZE = DEFAULT_COUNT_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic event_in,
  output logic led,
  output logic busy
);

  localparam logic [COUNT_SIZE-1:0] ON_LAST  = COUNT_SIZE'(ON_LIMIT - 1);
  localparam logic [COUNT_SIZE-1:0] GAP_LAST = COUNT_SIZE'(GAP_LIMIT - 1);

  led_state_t            state;
  logic [COUNT_SIZE-1:0] count;
  logic                  pending;

  // Single FSM block. led and busy are computed from the next state so they
  // are plain flops with no combinational path from event_in. The pending
  // flag is a single bit on purpose: any burst during a busy period earns
  // exactly one extra pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pending <= 1'b0;
      led     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count   <= '0;
          pending <= 1'b0;
          if (event_in) begin
            state <= ON;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end

        ON: begin
          // Events never extend the current pulse; they only queue one.
          pending <= pending | event_in;
          if (count == ON_LAST) begin
            state <= GAP;
            count <= '0;
            led   <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end

        GAP: begin
          if (count == GAP_LAST) begin
            count <= '0;
            // An event on the final gap cycle starts the next pulse directly
            // rather than being queued.
            if (pending || event_in) begin
              state   <= ON;
              pending <= 1'b0;
              led     <= 1'b1;
            end else begin
              state   <= IDLE;
              pending <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            count   <= count + 1'b1;
            pending <= pending | event_in;
          end
        end

        default: begin
          state   <= IDLE;
          count   <= '0;
          pending <= 1'b0;
          led     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_stretch.sv
// ---------------------------------------------------------------------------
// led_stretch
// Turns single-cycle internal event strobes into human-visible LED pulses
// with a guaranteed minimum on-time and off-gap per channel.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   event_in : [NUM_CHANNELS] per-channel event strobes
//   led_out  : [NUM_CHANNELS] registered LED drive, inverted when ACTIVE_LOW
//   busy_out : [NUM_CHANNELS] channel not idle, never inverted
// ---------------------------------------------------------------------------
module led_stretch
  import led_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ON_LIMIT     = DEFAULT_ON_LIMIT,
  parameter int unsigned GAP_LIMIT    = DEFAULT_GAP_LIMIT,
  parameter int unsigned COUNT_SIZE   = DEFAULT_COUNT_SIZE,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] event_in,
  output logic [NUM_CHANNELS-1:0] led_out,
  output logic [NUM_CHANNELS-1:0] busy_out
);

  localparam int unsigned MAX_LIMIT = (ON_LIMIT > GAP_LIMIT) ? ON_LIMIT : GAP_LIMIT;
  localparam logic [NUM_CHANNELS-1:0] POLARITY = ACTIVE_LOW ? '1 : '0;

  // Reject parameter sets the counter cannot represent.
  if (ON_LIMIT < 1 || GAP_LIMIT < 1) begin : g_bad_limits
    $error("led_stretch: ON_LIMIT and GAP_LIMIT must both be at least 1");
  end
  if (((MAX_LIMIT - 1) >> COUNT_SIZE) != 0) begin : g_bad_width
    $error("led_stretch: COUNT_SIZE too small for max(ON_LIMIT, GAP_LIMIT)-1");
  end

  logic [NUM_CHANNELS-1:0] led_raw;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    led_stretch_chan #(
      .ON_LIMIT   (ON_LIMIT),
      .GAP_LIMIT  (GAP_LIMIT),
      .COUNT_SIZE (COUNT_SIZE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .event_in (event_in[i]),
      .led      (led_raw[i]),
      .busy     (busy_out[i])
    );
  end

  // XOR with a constant keeps the pin flop-driven in either polarity.
  assign led_out = led_raw ^ POLARITY;

endmodule

// File: tb/tb_led_stretch.sv
// ---------------------------------------------------------------------------
// tb_led_stretch
// Self-checking bench for led_stretch with ON_LIMIT=4, GAP_LIMIT=3,
// two channels. An active-high and an active-low instance share all inputs.
// The reference model tracks each channel as an absolute pulse start cycle
// plus a queued flag and derives outputs from cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_led_stretch;

  localparam int ON  = 4;
  localparam int GAP = 3;
  localparam int NCH = 2;
  localparam int NO_PULSE = -1000000;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] event_in;
  logic [NCH-1:0] led_out;
  logic [NCH-1:0] busy_out;
  logic [NCH-1:0] led_out_al;
  logic [NCH-1:0] busy_out_al;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int             m_start  [NCH];
  bit             m_queued [NCH];
  logic [NCH-1:0] exp_led;
  logic [NCH-1:0] exp_busy;

  led_stretch #(
    .NUM_CHANNELS (NCH),
    .ON_LIMIT     (ON),
    .GAP_LIMIT    (GAP),
    .COUNT_SIZE   (3),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .led_out  (led_out),
    .busy_out (busy_out)
  );

  led_stretch #(
    .NUM_CHANNELS (NCH),
    .ON_LIMIT     (ON),
    .GAP_LIMIT    (GAP),
    .COUNT_SIZE   (3),
    .ACTIVE_LOW   (1'b1)
  ) dut_al (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .led_out  (led_out_al),
    .busy_out (busy_out_al)
  );

  always #5 clk = ~clk;

  // Reference model: inputs seen during cycle c produce expectations for c+1.
  task automatic model_step(input logic [NCH-1:0] ev, input logic rst, input int c);
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst) begin
        m_start[ch]  = NO_PULSE;
        m_queued[ch] = 0;
      end else begin
        int  last_c;
        bit  busy_now;
        last_c   = m_start[ch] + ON + GAP - 1;
        busy_now = (m_start[ch] != NO_PULSE) && (c >= m_start[ch]) && (c <= last_c);
        if (!busy_now) begin
          m_queued[ch] = 0;
          m_start[ch]  = ev[ch] ? c + 1 : NO_PULSE;
        end else if (c == last_c) begin
          if (ev[ch] || m_queued[ch]) m_start[ch] = c + 1;
          else                        m_start[ch] = NO_PULSE;
          m_queued[ch] = 0;
        end else if (ev[ch]) begin
          m_queued[ch] = 1;
        end
      end
      exp_busy[ch] = (m_start[ch] != NO_PULSE) && (c + 1 >= m_start[ch]) &&
                     (c + 1 <= m_start[ch] + ON + GAP - 1);
      exp_led[ch]  = exp_busy[ch] && (c + 1 < m_start[ch] + ON);
    end
  endtask

  // Drive one cycle of inputs, advance the clock and the model, then settle.
  task automatic tick(input logic [NCH-1:0] ev, input logic rst);
    event_in = ev;
    reset    = rst;
    @(posedge clk);
    model_step(ev, rst, cyc);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 12; k++) begin
      tick(2'b11 & {NCH{k < 2}}, k < 2);
      checks += 3;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL reset_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (busy_out !== exp_busy) begin
        failures++;
        $display("[TB] FAIL reset_busy cyc=%0d got=%b expected=%b", cyc, busy_out, exp_busy);
      end
      if (led_out_al !== ~exp_led) begin
        failures++;
        $display("[TB] FAIL reset_led_al cyc=%0d got=%b expected=%b", cyc, led_out_al, ~exp_led);
      end
    end
    checks++;
    if (busy_out !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_no_pulse got=%b expected=00", busy_out);
    end
  endtask

  task automatic test_single();
    int led_hi = 0;
    int busy_hi = 0;
    int ch1_hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick((k == 0) ? 2'b01 : 2'b00, 1'b0);
      led_hi  += led_out[0];
      busy_hi += busy_out[0];
      ch1_hi  += busy_out[1] | led_out[1];
      checks += 3;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL single_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (busy_out !== exp_busy) begin
        failures++;
        $display("[TB] FAIL single_busy cyc=%0d got=%b expected=%b", cyc, busy_out, exp_busy);
      end
      if (led_out_al !== ~exp_led) begin
        failures++;
        $display("[TB] FAIL single_led_al cyc=%0d got=%b expected=%b", cyc, led_out_al, ~exp_led);
      end
    end
    checks += 3;
    if (led_hi != ON) begin
      failures++;
      $display("[TB] FAIL single_on_cycles got=%0d expected=%0d", led_hi, ON);
    end
    if (busy_hi != ON + GAP) begin
      failures++;
      $display("[TB] FAIL single_busy_cycles got=%0d expected=%0d", busy_hi, ON + GAP);
    end
    if (ch1_hi != 0) begin
      failures++;
      $display("[TB] FAIL single_ch1_quiet got=%0d expected=0", ch1_hi);
    end
  endtask

  task automatic test_events_during_on();
    int led_hi = 0;
    for (int k = 0; k < 17; k++) begin
      tick((k == 0 || k == 2 || k == 3) ? 2'b01 : 2'b00, 1'b0);
      led_hi += led_out[0];
      checks += 2;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL during_on_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (busy_out !== exp_busy) begin
        failures++;
        $display("[TB] FAIL during_on_busy cyc=%0d got=%b expected=%b", cyc, busy_out, exp_busy);
      end
    end
    checks++;
    if (led_hi != 2 * ON) begin
      failures++;
      $display("[TB] FAIL during_on_two_pulses got=%0d expected=%0d", led_hi, 2 * ON);
    end
  endtask

  task automatic test_back_to_back();
    int busy_hi = 0;
    for (int k = 0; k < 17; k++) begin
      tick((k == 0 || k == 7) ? 2'b01 : 2'b00, 1'b0);
      busy_hi += busy_out[0];
      checks += 2;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL last_gap_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (busy_out !== exp_busy) begin
        failures++;
        $display("[TB] FAIL last_gap_busy cyc=%0d got=%b expected=%b", cyc, busy_out, exp_busy);
      end
    end
    checks++;
    if (busy_hi != 2 * (ON + GAP)) begin
      failures++;
      $display("[TB] FAIL last_gap_busy_span got=%0d expected=%0d", busy_hi, 2 * (ON + GAP));
    end
  endtask

  task automatic test_reset_mid_pulse();
    int led_hi = 0;
    for (int k = 0; k < 18; k++) begin
      tick((k == 0 || k == 1 || k == 6) ? 2'b01 : 2'b00, k == 2);
      if (k >= 2 && k < 6) led_hi += led_out[0] + busy_out[0];
      checks += 2;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL reset_mid_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (busy_out !== exp_busy) begin
        failures++;
        $display("[TB] FAIL reset_mid_busy cyc=%0d got=%b expected=%b", cyc, busy_out, exp_busy);
      end
    end
    checks++;
    if (led_hi != 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_quiet got=%0d expected=0", led_hi);
    end
  endtask

  task automatic test_independence();
    for (int k = 0; k < 12; k++) begin
      tick({k == 1, k == 0}, 1'b0);
      checks += 3;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL indep_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (led_out_al !== ~exp_led) begin
        failures++;
        $display("[TB] FAIL indep_led_al cyc=%0d got=%b expected=%b", cyc, led_out_al, ~exp_led);
      end
      if (busy_out_al !== exp_busy) begin
        failures++;
        $display("[TB] FAIL indep_busy_al cyc=%0d got=%b expected=%b", cyc, busy_out_al, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [NCH-1:0] ev;
      logic           rst;
      ev[0] = ($urandom_range(0, 3) == 0);
      ev[1] = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick(ev, rst);
      checks += 3;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL random_led cyc=%0d got=%b expected=%b", cyc, led_out, exp_led);
      end
      if (busy_out !== exp_busy) begin
        failures++;
        $display("[TB] FAIL random_busy cyc=%0d got=%b expected=%b", cyc, busy_out, exp_busy);
      end
      if (led_out_al !== ~exp_led) begin
        failures++;
        $display("[TB] FAIL random_led_al cyc=%0d got=%b expected=%b", cyc, led_out_al, ~exp_led);
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    event_in = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_start[ch]  = NO_PULSE;
      m_queued[ch] = 0;
    end
    @(negedge clk);
    $display("[TB] starting led_stretch tests");
    test_reset();
    test_single();
    test_events_during_on();
    test_back_to_back();
    test_reset_mid_pulse();
    test_independence();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_stretch.md
# led_stretch

Output-side human-interface block: turns single-cycle internal event strobes into LED pulses a person can see. It is the transmit counterpart of the switch debouncer and sits between core status/event logic and the board LED pins. Each channel guarantees a minimum on-time and a minimum off-gap, so closely spaced events appear as distinct blinks. Events that arrive while a channel is busy collapse into one queued pulse.

## Interface

- NUM_CHANNELS, 4: number of independent LED channels.
- ON_LIMIT, 600000: LED on-time in clk cycles (50 ms at 12 MHz); must be ≥1.
- GAP_LIMIT, 300000: forced off-time after each pulse, in clk cycles; must be ≥1.
- COUNT_SIZE, 20: counter width; must hold max(ON_LIMIT, GAP_LIMIT)-1.
- ACTIVE_LOW, 0: when 1, led_out is inverted at the pin (busy_out is never inverted).
- clk  input  1  single system clock.
- reset  input  1  synchronous, active-high reset.
- event_in  input  NUM_CHANNELS  per-channel event strobe; every cycle it is high counts as one event.
- led_out  output  NUM_CHANNELS  registered LED drive.
- busy_out  output  NUM_CHANNELS  channel state is not IDLE.

## Operation

- Each channel has its own FSM, a COUNT_SIZE counter and a 1-bit pending flag. The FSM has three states:
  - IDLE: LED off. An event moves the channel to ON with count=0.
  - ON: LED on. count increments each cycle. At count==ON_LIMIT-1 the channel moves to GAP with count=0.
  - GAP: LED off. count increments each cycle. At count==GAP_LIMIT-1:
    - go to ON with count=0 if pending is set or an event arrives this cycle;
    - otherwise go to IDLE.
- Pending flag:
  - Set by any event while the channel is in ON or GAP.
  - Cleared on every entry to ON.
  - It is one bit, so any number of events during a busy period yields exactly one extra pulse.
- Events during ON never extend the current pulse.
- An event on the cycle of the ON→GAP transition sets pending.
- An event on the final GAP cycle starts ON directly. The channel does not pass through IDLE and pending is not set.
- Reset:
  - All channels go to IDLE with count=0 and pending=0.
  - led_out = ACTIVE_LOW ? all-ones : 0; busy_out = 0.
  - Reset wins over a simultaneous event_in; that event is discarded.
  - Reset mid-ON or mid-GAP aborts immediately; nothing queued survives.
- Counter arithmetic is unsigned. The counter never wraps, because it is cleared at each limit.

## Timing

- Event sampled at the edge ending cycle t:
  - led_out is active during cycles t+1 … t+ON_LIMIT;
  - led_out is inactive during cycles t+ON_LIMIT+1 … t+ON_LIMIT+GAP_LIMIT;
  - the channel is back in IDLE at cycle t+ON_LIMIT+GAP_LIMIT+1 if no pulse is queued.
- Latency from event to LED is 1 cycle. busy_out rises on the same cycle as led_out.
- With a pulse queued, the next ON starts at cycle t+ON_LIMIT+GAP_LIMIT+1. That gives a pulse period of ON_LIMIT+GAP_LIMIT.
- led_out and busy_out come directly from flops, so there is no combinational path from event_in.

## Structure

- Shared package led_pkg:
  - FSM state typedef: IDLE, ON, GAP as a 2-bit encoding.
  - Default limit constants for 12 MHz.
- Sub-module led_stretch_chan holds one FSM, its counter and its pending flag. The top level generates NUM_CHANNELS instances and applies ACTIVE_LOW inversion.
- Elaboration-time checks:
  - ON_LIMIT ≥ 1 and GAP_LIMIT ≥ 1;
  - 2**COUNT_SIZE > max(ON_LIMIT, GAP_LIMIT)-1.

## Test plan

All scenarios use ON_LIMIT=4, GAP_LIMIT=3, COUNT_SIZE=3, NUM_CHANNELS=2, ACTIVE_LOW=0.

- Reset: hold reset 2 cycles with event_in=2'b11 → led_out=0 and busy_out=0 throughout and after; no pulse follows.
- Single event on ch0 at cycle t:
  - led_out[0]=1 exactly during cycles t+1..t+4 and 0 during t+5..t+7;
  - busy_out[0] falls at t+8;
  - ch1 stays idle.
- Events at t, t+2 and t+3 (during ON) → exactly two pulses: t+1..t+4 and t+8..t+11; idle at t+15.
- Event at t, then event at t+7 (last GAP cycle) → second pulse t+8..t+11; busy_out stays 1 continuously from t+1 to t+14.
- Reset asserted at t+2 of a pulse that has a pulse pending:
  - led_out=0 and busy_out=0 from t+3;
  - no queued pulse appears;
  - a fresh event at t+6 gives a pulse at t+7..t+10.
- Channel independence: ch0 event at t and ch1 event at t+1 → overlapping pulses t+1..t+4 and t+2..t+5 with no cross-effects. Repeat with ACTIVE_LOW=1 and check that led_out is inverted.
